// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the multiplier result accumulator.
//   - Mode encodings of the upstream configurable multiplier (cm).
//   - Accumulator FSM state type.
//   - Default accumulator / product-count widths.
package mult_pkg;

    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] CM_8X8   = 2'b00;
    localparam logic [1:0] CM_DUAL8 = 2'b01;
    localparam logic [1:0] CM_16X16 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/mult_result_accumulator_if.sv
// mult_result_accumulator_if: bundles the product input, run control and
// result handshake of mult_result_accumulator.
//   product_i/product_valid_i : multiplier product and its level valid
//   cm_i/count_i/start_i      : run mode, products per run, start pulse
//   busy_o                    : run in progress or result pending
//   acc0_o/acc1_o/ovf_o       : lane sums and sticky overflow
//   result_valid_o/ready_i    : result handshake
// Modports: slave = accumulator side, master = producer/consumer side.
interface mult_result_accumulator_if
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();
    logic [31:0]             product_i;
    logic                    product_valid_i;
    logic [1:0]              cm_i;
    logic [CNT_W-1:0]        count_i;
    logic                    start_i;
    logic                    busy_o;
    logic signed [ACC_W-1:0] acc0_o;
    logic signed [ACC_W-1:0] acc1_o;
    logic                    result_valid_o;
    logic                    result_ready_i;
    logic                    ovf_o;

    modport slave (
        input  product_i, product_valid_i, cm_i, count_i, start_i, result_ready_i,
        output busy_o, acc0_o, acc1_o, result_valid_o, ovf_o
    );

    modport master (
        output product_i, product_valid_i, cm_i, count_i, start_i, result_ready_i,
        input  busy_o, acc0_o, acc1_o, result_valid_o, ovf_o
    );
endinterface

// File: rtl/mult_result_accumulator_acc_lane.sv
// acc_lane: one signed ACC_W accumulator with signed-overflow detection.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : clear sum and overflow (start of a run)
//   add_i, term_i  : add the sign-extended term this cycle
//   acc_o          : running sum
//   ovf_o          : sticky overflow since the last clear/reset
// Build option: ACC_SATURATE_EN clamps the sum to the ACC_W limits on
// overflow; without it the sum wraps. ovf_o is set in both builds.
module acc_lane
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clr_i,
    input  logic                    add_i,
    input  logic signed [ACC_W-1:0] term_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic                    ovf_o
);
`ifdef ACC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow only when both operands share a sign the wrapped sum lacks.
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b,
                                     input logic signed [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    // On overflow both operands carry the sign of a, so that picks the rail.
    function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] s,
                                                        input logic ovf);
        logic signed [ACC_W-1:0] rail;
        rail = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        return (ovf && SAT_EN) ? rail : s;
    endfunction

    logic signed [ACC_W-1:0] sum_p0;
    logic                    ovf_p0;

    assign sum_p0 = acc_o + term_i;
    assign ovf_p0 = add_ovf(acc_o, term_i, sum_p0);

    // stage p0 -> register
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            acc_o <= '0;
            ovf_o <= 1'b0;
        end else if (add_i) begin
            acc_o <= sat_sum(acc_o, sum_p0, ovf_p0);
            ovf_o <= ovf_o | ovf_p0;
        end
    end
endmodule

// File: rtl/mult_result_accumulator.sv
// mult_result_accumulator: captures multiplier products on the rising edge
// of product_valid_i, unpacks them by mode (single 8x8, dual 8x8, 16x16),
// sums count_i products per run into two signed lanes and offers the sums on
// a valid/ready handshake.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (slave)    : product input, run control, result handshake
// Build option: ACC_SATURATE_EN (lane saturation instead of wrap).
module mult_result_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    mult_result_accumulator_if.slave   bus
);
    acc_state_t              state_q, state_d;
    logic [1:0]              mode_q;
    logic [CNT_W-1:0]        rem_q;
    logic                    prev_valid_q;
    logic                    capture;
    logic                    add_en;
    logic                    start_run;
    logic signed [31:0]      p32;
    logic signed [15:0]      lo16, hi16;
    logic signed [ACC_W-1:0] term0, term1;
    logic signed [ACC_W-1:0] acc0, acc1;
    logic                    ovf0, ovf1;

    assign capture   = bus.product_valid_i & ~prev_valid_q;
    // Capture is ignored in IDLE (including the start edge) and in DONE.
    assign add_en    = capture && (state_q == ACCUM);
    assign start_run = (state_q == IDLE) && bus.start_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_i) state_d = (bus.count_i == '0) ? DONE : ACCUM;
            ACCUM:   if (add_en && rem_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (bus.result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // stage p0: run control registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q       <= CM_8X8;
            rem_q        <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_valid_q <= bus.product_valid_i;
            if (start_run) begin
                mode_q <= (bus.cm_i == 2'b11) ? CM_16X16 : bus.cm_i;
                rem_q  <= bus.count_i;
            end else if (add_en) begin
                rem_q  <= rem_q - CNT_W'(1);
            end
        end
    end

    assign p32  = bus.product_i;
    assign lo16 = bus.product_i[15:0];
    assign hi16 = bus.product_i[31:16];

    // Lane 1 only receives a non-zero term in dual mode, so it stays 0 otherwise.
    always_comb begin
        term0 = ACC_W'(lo16);
        term1 = '0;
        unique case (mode_q)
            CM_16X16: term0 = ACC_W'(p32);
            CM_DUAL8: begin
                term0 = ACC_W'(lo16);
                term1 = ACC_W'(hi16);
            end
            default:  term0 = ACC_W'(lo16);
        endcase
    end

    acc_lane #(.ACC_W(ACC_W)) u_lane0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (start_run),
        .add_i   (add_en),
        .term_i  (term0),
        .acc_o   (acc0),
        .ovf_o   (ovf0)
    );

    acc_lane #(.ACC_W(ACC_W)) u_lane1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (start_run),
        .add_i   (add_en),
        .term_i  (term1),
        .acc_o   (acc1),
        .ovf_o   (ovf1)
    );

    assign bus.busy_o         = (state_q != IDLE);
    assign bus.result_valid_o = (state_q == DONE);
    assign bus.acc0_o         = acc0;
    assign bus.acc1_o         = acc1;
    assign bus.ovf_o          = ovf0 | ovf1;
endmodule

// File: tb/tb_mult_result_accumulator.sv
// tb_mult_result_accumulator: directed and randomized bench for
// mult_result_accumulator. Two instances (ACC_W=40 and ACC_W=33) see the
// same stimulus; a plain-arithmetic reference model predicts both.
// Honors ACC_SATURATE_EN in the model.
module tb_mult_result_accumulator;
    import mult_pkg::*;

    localparam int CW = 8;

`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    mult_result_accumulator_if #(.ACC_W(40), .CNT_W(CW)) bus ();
    mult_result_accumulator_if #(.ACC_W(33), .CNT_W(CW)) bus33 ();

    assign bus33.product_i       = bus.product_i;
    assign bus33.product_valid_i = bus.product_valid_i;
    assign bus33.cm_i            = bus.cm_i;
    assign bus33.count_i         = bus.count_i;
    assign bus33.start_i         = bus.start_i;
    assign bus33.result_ready_i  = bus.result_ready_i;

    mult_result_accumulator #(.ACC_W(40), .CNT_W(CW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    mult_result_accumulator #(.ACC_W(33), .CNT_W(CW)) dut33 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus33)
    );

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    int     W [2] = '{40, 33};
    longint m_a0 [2];
    longint m_a1 [2];
    bit     m_ovf [2];
    int     m_rem;
    int     m_mode;

    task automatic lane_add(inout longint acc, input longint t, input int w, inout bit ovf);
        longint s, mx, mn, span;
        span = longint'(1) <<< w;
        mx   = (longint'(1) <<< (w - 1)) - 1;
        mn   = -mx - 1;
        s    = acc + t;
        if (s > mx || s < mn) begin
            ovf = 1'b1;
            if (SAT) s = (s > mx) ? mx : mn;
            else     s = (s > mx) ? s - span : s + span;
        end
        acc = s;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_a0[k] = 0; m_a1[k] = 0; m_ovf[k] = 1'b0;
        end
        m_rem = 0;
    endtask

    task automatic model_start(input int cm, input int cnt);
        model_reset();
        m_mode = (cm == 3) ? 2 : cm;
        m_rem  = cnt;
    endtask

    task automatic model_capture(input logic [31:0] p);
        longint t0, t1;
        logic [15:0] lo, hi;
        if (m_rem == 0) return;
        lo = p[15:0];
        hi = p[31:16];
        t1 = 0;
        if (m_mode == 2)      t0 = longint'(int'(p));
        else                  t0 = longint'(shortint'(lo));
        if (m_mode == 1)      t1 = longint'(shortint'(hi));
        for (int k = 0; k < 2; k++) begin
            lane_add(m_a0[k], t0, W[k], m_ovf[k]);
            lane_add(m_a1[k], t1, W[k], m_ovf[k]);
        end
        m_rem--;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [31:0] p);
        bus.product_i       = p;
        bus.product_valid_i = 1'b1;
        model_capture(p);
        tick();
        bus.product_valid_i = 1'b0;
        tick();
    endtask

    task automatic start_run(input int cm, input int cnt);
        bus.cm_i    = 2'(cm);
        bus.count_i = CW'(cnt);
        bus.start_i = 1'b1;
        model_start(cm, cnt);
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.result_valid_o) break;
            tick();
        end
        check({tag, ".valid"}, bus.result_valid_o, 1);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".acc0"},   bus.acc0_o,   m_a0[0]);
        check({tag, ".acc1"},   bus.acc1_o,   m_a1[0]);
        check({tag, ".ovf"},    bus.ovf_o,    m_ovf[0]);
        check({tag, ".acc0_33"}, bus33.acc0_o, m_a0[1]);
        check({tag, ".acc1_33"}, bus33.acc1_o, m_a1[1]);
        check({tag, ".ovf_33"},  bus33.ovf_o,  m_ovf[1]);
    endtask

    task automatic accept(input string tag);
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        check({tag, ".busy_after"},  bus.busy_o,         0);
        check({tag, ".valid_after"}, bus.result_valid_o, 0);
    endtask

    initial begin
        logic signed [63:0] held;
        int cm, cnt, d;

        bus.product_i       = '0;
        bus.product_valid_i = 1'b0;
        bus.cm_i            = '0;
        bus.count_i         = '0;
        bus.start_i         = 1'b0;
        bus.result_ready_i  = 1'b0;
        reset_i             = 1'b1;
        model_reset();
        m_mode = 0;
        tick();
        tick();
        reset_i = 1'b0;
        check("rst.busy",  bus.busy_o,         0);
        check("rst.valid", bus.result_valid_o, 0);
        check("rst.acc0",  bus.acc0_o,         0);
        check("rst.acc1",  bus.acc1_o,         0);
        check("rst.ovf",   bus.ovf_o,          0);

        // 16x16, four identical products; valid one cycle after the 4th edge
        start_run(2, 4);
        check("m10.busy", bus.busy_o, 1);
        for (int i = 0; i < 3; i++) pulse(32'hF7F6_901E);
        check("m10.valid_early", bus.result_valid_o, 0);
        bus.product_i       = 32'hF7F6_901E;
        bus.product_valid_i = 1'b1;
        model_capture(32'hF7F6_901E);
        tick();
        check("m10.valid_latency", bus.result_valid_o, 1);
        bus.product_valid_i = 1'b0;
        tick();
        check_outputs("m10");
        check("m10.const", bus.acc0_o, -64'sd539344776);
        accept("m10");

        // dual 8x8
        start_run(1, 3);
        for (int i = 0; i < 3; i++) pulse({16'hFFFA, 16'h0064});
        wait_valid("m01");
        check_outputs("m01");
        check("m01.const0", bus.acc0_o, 300);
        check("m01.const1", bus.acc1_o, -18);
        accept("m01");

        // single 8x8: upper half ignored
        start_run(0, 2);
        for (int i = 0; i < 2; i++) pulse(32'hDEAD_FF38);
        wait_valid("m00");
        check_outputs("m00");
        check("m00.const", bus.acc0_o, -400);
        accept("m00");

        // held valid counts once; backpressure keeps result stable
        start_run(2, 1);
        bus.product_i       = 32'd5;
        bus.product_valid_i = 1'b1;
        model_capture(32'd5);
        repeat (20) tick();
        bus.product_valid_i = 1'b0;
        tick();
        wait_valid("hold");
        held = bus.acc0_o;
        check("hold.acc0", bus.acc0_o, 5);
        for (int i = 0; i < 5; i++) pulse($urandom);
        check("hold.stable", bus.acc0_o, held);
        check("hold.busy",   bus.busy_o, 1);
        check("hold.valid",  bus.result_valid_o, 1);
        check_outputs("hold");
        accept("hold");

        // overflow: narrow instance exceeds 33-bit range
        start_run(2, 3);
        for (int i = 0; i < 3; i++) pulse(32'h7FFF_FFFF);
        wait_valid("ovf");
        check_outputs("ovf");
        check("ovf.flag33", bus33.ovf_o, 1);
        check("ovf.flag40", bus.ovf_o,   0);
        accept("ovf");

        // reset mid-run aborts everything
        start_run(2, 4);
        pulse(32'h100);
        pulse(32'h100);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        model_reset();
        check("midrst.busy",  bus.busy_o,         0);
        check("midrst.valid", bus.result_valid_o, 0);
        check("midrst.acc0",  bus.acc0_o,         0);
        check("midrst.acc1",  bus.acc1_o,         0);
        check("midrst.ovf",   bus.ovf_o,          0);
        start_run(2, 1);
        pulse(32'h123);
        wait_valid("post");
        check("post.acc0", bus.acc0_o, 32'h123);
        accept("post");

        // count 0 goes straight to DONE with zero sums
        start_run(1, 0);
        check("cnt0.valid", bus.result_valid_o, 1);
        check("cnt0.acc0",  bus.acc0_o, 0);
        check("cnt0.acc1",  bus.acc1_o, 0);
        accept("cnt0");

        // reserved mode behaves as 16x16
        start_run(3, 2);
        pulse(32'hFFFF_FFF9);
        pulse(32'h0001_0000);
        wait_valid("cm11");
        check("cm11.acc0", bus.acc0_o, 65529);
        check("cm11.acc1", bus.acc1_o, 0);
        accept("cm11");

        // valid rising on the start edge is not counted; start in ACCUM ignored
        bus.product_i       = 32'h40;
        bus.product_valid_i = 1'b1;
        start_run(2, 1);
        repeat (2) tick();
        bus.product_valid_i = 1'b0;
        tick();
        check("sedge.valid", bus.result_valid_o, 0);
        bus.cm_i    = 2'b01;
        bus.count_i = CW'(9);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        pulse(32'h7);
        wait_valid("sedge");
        check("sedge.acc0", bus.acc0_o, 7);
        check_outputs("sedge");
        accept("sedge");

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            cm  = int'($urandom_range(0, 3));
            cnt = int'($urandom_range(1, 6));
            start_run(cm, cnt);
            for (int i = 0; i < cnt; i++) pulse($urandom);
            wait_valid($sformatf("rnd%0d", r));
            d = int'($urandom_range(0, 3));
            repeat (d) tick();
            check_outputs($sformatf("rnd%0d", r));
            accept($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
